// File: rtl/synth_voice_scheduler.sv
// Keypad-to-voice scheduler: synchronise/debounce keys, allocate voices (with stealing), round-robin
// note stream over valid/ready. Optional sustain pedal enabled by defining SYNTH_SCHED_SUSTAIN_EN.
module synth_voice_scheduler #(
  parameter  int NUM_VOICES   = 4,
  parameter  int DEBOUNCE_DIV = 1000,
  localparam int VW           = $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [14:0]           keypad_i,
`ifdef SYNTH_SCHED_SUSTAIN_EN
  input  logic                  sustain_i,
`endif
  output logic [3:0]            note_o,
  output logic [VW-1:0]         voice_o,
  output logic                  note_valid_o,
  input  logic                  note_ready_i,
  output logic [NUM_VOICES-1:0] active_o
);
  localparam int CW = $clog2(DEBOUNCE_DIV);

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  logic [14:0]           sync1_q, sync2_q, samp_q, samp_d, deb_q, deb_d;
  logic [14:0]           press_q, press_d, rel_q, rel_d, agree, edge_m;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  tick;
  logic [NUM_VOICES-1:0] act_q, act_d;
  logic [3:0]            key_q [NUM_VOICES];
  logic [3:0]            key_d [NUM_VOICES];
  logic [VW-1:0]         steal_q, steal_d, rr_q, rr_nxt, hit_v, free_v;
  logic [3:0]            ev_key, pres_note, note_q;
  logic                  ev_vld, ev_rel, hit, free_any, valid_q;
  state_t                state_q;
`ifdef SYNTH_SCHED_SUSTAIN_EN
  logic                  sus1_q, sus2_q, sus_prev_q;
  logic [NUM_VOICES-1:0] sus_q, sus_d;
`endif

  always_comb begin
    tick   = (cnt_q == CW'(DEBOUNCE_DIV - 1));
    cnt_d  = tick ? '0 : cnt_q + CW'(1);
    samp_d = tick ? sync2_q : samp_q;
    agree  = ~(sync2_q ^ samp_q);
    deb_d  = tick ? ((agree & sync2_q) | (~agree & deb_q)) : deb_q;
    edge_m = deb_d ^ deb_q;

    // Releases outrank presses; lowest key index wins inside each class.
    ev_key = '0;
    ev_rel = 1'b0;
    for (int k = 14; k >= 0; k--) if (press_q[k]) ev_key = 4'(k);
    for (int k = 14; k >= 0; k--) if (rel_q[k]) begin ev_key = 4'(k); ev_rel = 1'b1; end
    ev_vld = (|press_q) | (|rel_q);

    hit      = 1'b0;
    hit_v    = '0;
    free_any = 1'b0;
    free_v   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (act_q[v] && key_q[v] == ev_key) begin hit = 1'b1; hit_v = VW'(v); end
      if (!act_q[v]) begin free_any = 1'b1; free_v = VW'(v); end
    end

    press_d = press_q;
    rel_d   = rel_q;
    act_d   = act_q;
    key_d   = key_q;
    steal_d = steal_q;
`ifdef SYNTH_SCHED_SUSTAIN_EN
    sus_d   = sus_q;
`endif
    if (ev_vld) begin
      if (ev_rel) begin
        rel_d[ev_key] = 1'b0;
`ifdef SYNTH_SCHED_SUSTAIN_EN
        if (hit && sus2_q) sus_d[hit_v] = 1'b1;
        else if (hit) act_d[hit_v] = 1'b0;
`else
        if (hit) act_d[hit_v] = 1'b0;
`endif
      end else begin
        press_d[ev_key] = 1'b0;
        if (hit) begin
`ifdef SYNTH_SCHED_SUSTAIN_EN
          sus_d[hit_v] = 1'b0;
`endif
        end else if (free_any) begin
          act_d[free_v] = 1'b1;
          key_d[free_v] = ev_key;
`ifdef SYNTH_SCHED_SUSTAIN_EN
          sus_d[free_v] = 1'b0;
`endif
        end else begin
          key_d[steal_q] = ev_key;
          steal_d        = steal_q + VW'(1);
`ifdef SYNTH_SCHED_SUSTAIN_EN
          sus_d[steal_q] = 1'b0;
`endif
        end
      end
    end
    // A fresh debounced edge replaces whatever was still pending for that key.
    press_d = (press_d & ~edge_m) | (edge_m & deb_d);
    rel_d   = (rel_d & ~edge_m) | (edge_m & deb_q);
`ifdef SYNTH_SCHED_SUSTAIN_EN
    if (sus_prev_q && !sus2_q) begin
      act_d = act_d & ~sus_d;
      sus_d = '0;
    end
`endif
    if (!en) begin
      act_d   = '0;
      press_d = '0;
      rel_d   = '0;
`ifdef SYNTH_SCHED_SUSTAIN_EN
      sus_d   = '0;
`endif
    end

    rr_nxt    = (valid_q && note_ready_i) ? rr_q + VW'(1) : rr_q;
    pres_note = act_q[rr_nxt] ? key_q[rr_nxt] : 4'hF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      samp_q  <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      act_q   <= '0;
      steal_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) key_q[v] <= 4'hF;
`ifdef SYNTH_SCHED_SUSTAIN_EN
      sus1_q     <= 1'b0;
      sus2_q     <= 1'b0;
      sus_prev_q <= 1'b0;
      sus_q      <= '0;
`endif
    end else begin
      sync1_q <= keypad_i;
      sync2_q <= sync1_q;
      samp_q  <= samp_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      act_q   <= act_d;
      steal_q <= steal_d;
      key_q   <= key_d;
`ifdef SYNTH_SCHED_SUSTAIN_EN
      sus1_q     <= sustain_i;
      sus2_q     <= sus1_q;
      sus_prev_q <= sus2_q;
      sus_q      <= sus_d;
`endif
    end
  end

  // Note is looked up from the pre-update table, so same-cycle allocations show on the next presentation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      note_q  <= 4'hF;
      rr_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en) begin
            state_q <= S_PRESENT;
            valid_q <= 1'b1;
            note_q  <= act_q[rr_q] ? key_q[rr_q] : 4'hF;
          end
        end
        default: begin
          rr_q <= rr_nxt;
          if (!en) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            note_q  <= 4'hF;
          end else begin
            note_q  <= pres_note;
          end
        end
      endcase
    end
  end

  assign note_o       = note_q;
  assign voice_o      = rr_q;
  assign note_valid_o = valid_q;
  assign active_o     = act_q;
endmodule

// File: tb/tb_synth_voice_scheduler.sv
// Directed bench for synth_voice_scheduler (NUM_VOICES = 4, DEBOUNCE_DIV = 4).
module tb_synth_voice_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [14:0] keypad_i;
  logic [3:0]  note_o;
  logic [1:0]  voice_o;
  logic        note_valid_o;
  logic        note_ready_i;
  logic [3:0]  active_o;
`ifdef SYNTH_SCHED_SUSTAIN_EN
  logic        sustain_i;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  synth_voice_scheduler #(.NUM_VOICES(4), .DEBOUNCE_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .keypad_i     (keypad_i),
`ifdef SYNTH_SCHED_SUSTAIN_EN
    .sustain_i    (sustain_i),
`endif
    .note_o       (note_o),
    .voice_o      (voice_o),
    .note_valid_o (note_valid_o),
    .note_ready_i (note_ready_i),
    .active_o     (active_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_active(input logic [3:0] exp, input int bound);
    int i = 0;
    while (active_o !== exp && i < bound) begin
      @(negedge clk);
      i++;
    end
  endtask

  task automatic wait_voice(input logic [1:0] v);
    int i = 0;
    @(negedge clk);
    while (!(note_valid_o === 1'b1 && voice_o === v) && i < 8) begin
      @(negedge clk);
      i++;
    end
  endtask

  task automatic note_of(input string tag, input logic [1:0] v, input logic [3:0] exp);
    wait_voice(v);
    chk(tag, {26'd0, voice_o, note_o}, {26'd0, v, exp});
  endtask

  initial begin
    logic [1:0] v_hold;
    rst = 1'b1; en = 1'b0; keypad_i = '0; note_ready_i = 1'b0;
`ifdef SYNTH_SCHED_SUSTAIN_EN
    sustain_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_active", active_o, 4'h0);
    chk("rst_note",   note_o, 4'hF);
    chk("rst_voice",  voice_o, 2'd0);
    chk("rst_valid",  note_valid_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    en = 1'b1; note_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_rr", {27'd0, note_valid_o, voice_o, note_o}, {27'd0, 1'b1, 2'(i % 4), 4'hF});
    end
    chk("idle_active", active_o, 4'h0);

    keypad_i[5] = 1'b1;
    wait_active(4'b0001, 12);
    chk("press5_active", active_o, 4'b0001);
    note_of("press5_note", 2'd0, 4'd5);
    keypad_i = '0;
    wait_active(4'b0000, 12);
    chk("rel5_active", active_o, 4'b0000);

    for (int i = 0; i < 6; i++) begin
      keypad_i[2] = ~keypad_i[2];
      repeat (4) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("bounce_none", active_o, 4'b0000);
    keypad_i[2] = 1'b1;
    wait_active(4'b0001, 12);
    chk("stable2_active", active_o, 4'b0001);
    note_of("stable2_note", 2'd0, 4'd2);
    keypad_i = '0;
    wait_active(4'b0000, 12);
    chk("rel2_active", active_o, 4'b0000);

    keypad_i = 15'h001E;
    wait_active(4'b1111, 16);
    chk("fill_active", active_o, 4'b1111);
    note_of("fill_v3", 2'd3, 4'd4);
    keypad_i[7] = 1'b1;
    repeat (14) @(negedge clk);
    note_of("steal7_v0", 2'd0, 4'd7);
    note_of("steal7_v1", 2'd1, 4'd2);
    keypad_i[1] = 1'b0;
    repeat (14) @(negedge clk);
    chk("drop1_active", active_o, 4'b1111);
    note_of("drop1_v0", 2'd0, 4'd7);
    keypad_i[8] = 1'b1;
    repeat (14) @(negedge clk);
    note_of("steal8_v1", 2'd1, 4'd8);
    keypad_i = '0;
    wait_active(4'b0000, 16);
    chk("relall_active", active_o, 4'b0000);

    keypad_i[9] = 1'b1;
    wait_active(4'b0001, 12);
    chk("press9_active", active_o, 4'b0001);
    wait_voice(2'd0);
    note_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", {25'd0, note_valid_o, voice_o, note_o}, {25'd0, 1'b1, 2'd0, 4'd9});
    end
    note_ready_i = 1'b1;
    @(negedge clk);
    chk("stall_release", voice_o, 2'd1);

    note_ready_i = 1'b0;
    v_hold = voice_o;
    en = 1'b0;
    @(negedge clk);
    chk("dis_state", {25'd0, note_valid_o, active_o, note_o}, {25'd0, 1'b0, 4'b0000, 4'hF});
    chk("dis_ptr", voice_o, v_hold);
    en = 1'b1; note_ready_i = 1'b1;
    repeat (20) @(negedge clk);
    chk("reen_noevent", active_o, 4'b0000);

    keypad_i[6] = 1'b1;
    wait_active(4'b0001, 12);
    chk("press6_active", active_o, 4'b0001);
    #2 rst = 1'b1;
    #1;
    chk("midrst", {22'd0, note_valid_o, voice_o, note_o, active_o}, {22'd0, 1'b0, 2'd0, 4'hF, 4'h0});
    keypad_i = '0;
    @(negedge clk);
    rst = 1'b0;

`ifdef SYNTH_SCHED_SUSTAIN_EN
    @(negedge clk);
    en = 1'b1; sustain_i = 1'b1;
    keypad_i[3] = 1'b1;
    wait_active(4'b0001, 12);
    chk("sus_press3", active_o, 4'b0001);
    keypad_i[3] = 1'b0;
    repeat (14) @(negedge clk);
    chk("sus_held", active_o, 4'b0001);
    sustain_i = 1'b0;
    wait_active(4'b0000, 6);
    chk("sus_free", active_o, 4'b0000);
    note_of("sus_note", 2'd0, 4'hF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
